// File: rtl/avalon_ram_responder.sv
// Avalon-MM slave backed by a word RAM: fixed wait-state timing, byte-lane writes,
// and a sticky protocol_error for misaligned, conflicting or abandoned requests.
module avalon_ram_responder #(
  parameter int unsigned MEM_WORDS_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR      = 32'hBFC00000,
  parameter int unsigned WAIT_CYCLES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        protocol_error
);

  localparam int unsigned MEM_WORDS = 1 << MEM_WORDS_LOG2;
  localparam logic [32:0] MEM_SPAN  = 33'(1) << (MEM_WORDS_LOG2 + 2);
  localparam logic [7:0]  CNT_INIT  = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q;
  logic        rd_q;
  logic        wr_q;
  logic [3:0]  be_q;
  logic [31:0] wd_q;
  logic [31:0] readdata_q;
  logic        error_q;

  logic [31:0] mem [MEM_WORDS];

  logic [31:0]               cur_addr;
  logic [31:0]               offset;
  logic                      in_range;
  logic                      aligned;
  logic                      addr_ok;
  logic [MEM_WORDS_LOG2-1:0] idx;
  logic [31:0]               rd_word;
  logic                      one_req;
  logic                      both_req;
  logic                      changed;
  logic                      mem_we;

  // In IDLE decode the live bus; afterwards decode the latched transfer.
  always_comb begin
    cur_addr = (state_q == S_IDLE) ? address : addr_q;
    offset   = cur_addr - BASE_ADDR;
    in_range = ({1'b0, offset} < MEM_SPAN);
    aligned  = (cur_addr[1:0] == 2'b00);
    addr_ok  = in_range && aligned;
    idx      = offset[MEM_WORDS_LOG2+1:2];
    rd_word  = addr_ok ? mem[idx] : 32'h0;
    one_req  = read ^ write;
    both_req = read & write;
    changed  = (address != addr_q) || (read != rd_q) || (write != wr_q);
    mem_we   = (state_q == S_ACK) && wr_q && !changed && addr_ok && !reset;
  end

  assign waitrequest    = reset || (state_q == S_WAIT) || ((state_q == S_IDLE) && one_req);
  assign readdata       = readdata_q;
  assign protocol_error = error_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      addr_q     <= 32'h0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      be_q       <= 4'h0;
      wd_q       <= 32'h0;
      readdata_q <= 32'h0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (both_req) begin
            error_q <= 1'b1;
          end else if (one_req) begin
            addr_q <= address;
            rd_q   <= read;
            wr_q   <= write;
            be_q   <= byteenable;
            wd_q   <= writedata;
            if (!aligned) error_q <= 1'b1;
            if (WAIT_CYCLES != 0) begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
            end else begin
              state_q <= S_ACK;
              if (read) readdata_q <= rd_word;
            end
          end
        end
        S_WAIT: begin
          if (changed) begin
            state_q <= S_IDLE;
            error_q <= 1'b1;
          end else if (cnt_q == 8'd0) begin
            state_q <= S_ACK;
            if (rd_q) readdata_q <= rd_word;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
          if (changed) error_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // RAM is never cleared by reset; lanes commit on the edge that ends ACK.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wd_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_avalon_ram_responder.sv
// Bench for avalon_ram_responder: one unit with 2 wait states, one with none,
// each tracked by a transfer-level model and checked every cycle.
module tb_avalon_ram_responder;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk;
  logic        reset;
  logic        run;
  logic [31:0] addr_s [2];
  logic        rd_s   [2];
  logic        wr_s   [2];
  logic [3:0]  be_s   [2];
  logic [31:0] wd_s   [2];
  logic        wreq   [2];
  logic [31:0] rdat   [2];
  logic        perr   [2];

  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s unit%0d got %h expected %h", name, u, act, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off < 32'd4096) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [9:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return off[9:0];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int unsigned WC = (g == 0) ? 2 : 0;

    avalon_ram_responder #(
      .MEM_WORDS_LOG2(10),
      .BASE_ADDR     (BASE),
      .WAIT_CYCLES   (WC)
    ) dut (
      .clk           (clk),
      .reset         (reset),
      .address       (addr_s[g]),
      .read          (rd_s[g]),
      .write         (wr_s[g]),
      .byteenable    (be_s[g]),
      .writedata     (wd_s[g]),
      .waitrequest   (wreq[g]),
      .readdata      (rdat[g]),
      .protocol_error(perr[g])
    );

    // Transfer-level model: a request ages one step per edge; it is acknowledged at age WC+1.
    logic [31:0] mm [1024];
    bit          busy    = 1'b0;
    int          elapsed = 0;
    logic [31:0] la;
    logic        lr, lw;
    logic [3:0]  lbe;
    logic [31:0] lwd;
    logic [31:0] m_rdata = 32'h0;
    logic        m_err   = 1'b0;
    logic        ew;

    always @(posedge clk or posedge reset) begin
      if (reset) begin
        busy = 1'b0; elapsed = 0; m_rdata = 32'h0; m_err = 1'b0;
      end else if (busy) begin
        if (addr_s[g] != la || rd_s[g] != lr || wr_s[g] != lw) begin
          busy = 1'b0; m_err = 1'b1;
        end else if (elapsed == int'(WC) + 1) begin
          if (lw && addr_ok(la))
            for (int i = 0; i < 4; i++)
              if (lbe[i]) mm[word_of(la)][8*i +: 8] = lwd[8*i +: 8];
          busy = 1'b0;
        end else begin
          elapsed++;
          if (elapsed == int'(WC) + 1 && lr) m_rdata = addr_ok(la) ? mm[word_of(la)] : 32'h0;
        end
      end else if (rd_s[g] && wr_s[g]) begin
        m_err = 1'b1;
      end else if (rd_s[g] ^ wr_s[g]) begin
        busy = 1'b1; elapsed = 1;
        la = addr_s[g]; lr = rd_s[g]; lw = wr_s[g]; lbe = be_s[g]; lwd = wd_s[g];
        if (la[1:0] != 2'b00) m_err = 1'b1;
        if (WC == 0 && lr) m_rdata = addr_ok(la) ? mm[word_of(la)] : 32'h0;
      end
    end

    always @(negedge clk) begin
      if (run) begin
        ew = reset ? 1'b1 : (busy ? (elapsed <= int'(WC)) : (rd_s[g] ^ wr_s[g]));
        check("waitrequest", g, 32'(wreq[g]), 32'(ew));
        check("readdata", g, rdat[g], m_rdata);
        check("protocol_error", g, 32'(perr[g]), 32'(m_err));
      end
    end
  end

  // Issue a request at posedge+1 and hold it through the completing edge.
  task automatic xfer(input int n, input bit w, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd, output logic [31:0] rdv, output int hi);
    bit done;
    done = 1'b0; hi = 0; rdv = 32'h0;
    rd_s[n] = !w; wr_s[n] = w; addr_s[n] = a; be_s[n] = be; wd_s[n] = wd;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (!wreq[n]) begin
        rdv  = rdat[n];
        done = 1'b1;
      end else begin
        hi++;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout unit%0d got waitrequest stuck high expected completion", n);
    end
  endtask

  task automatic idle(input int n);
    rd_s[n] = 1'b0; wr_s[n] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  logic [31:0] rv;
  int          hi;

  initial begin
    run = 1'b0;
    reset = 1'b0;
    for (int n = 0; n < 2; n++) begin
      addr_s[n] = 32'h0; rd_s[n] = 1'b0; wr_s[n] = 1'b0; be_s[n] = 4'h0; wd_s[n] = 32'h0;
    end
    #1 reset = 1'b1;
    run = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_perr", 0, 32'(perr[0]), 32'h0);
    check("reset_rdata", 0, rdat[0], 32'h0);
    @(posedge clk); #1;

    // Two-wait-state unit: basic write/read, byte lanes, empty enable, address faults.
    xfer(0, 1'b1, 32'hBFC00004, 4'b1111, 32'hDEADBEEF, rv, hi);
    check("wr_hi_cycles", 0, 32'(hi), 32'd3);
    idle(0);
    xfer(0, 1'b0, 32'hBFC00004, 4'b0000, 32'h0, rv, hi);
    check("rd_deadbeef", 0, rv, 32'hDEADBEEF);
    check("rd_hi_cycles", 0, 32'(hi), 32'd3);
    idle(0);
    xfer(0, 1'b1, 32'hBFC00004, 4'b0101, 32'h11223344, rv, hi);
    idle(0);
    xfer(0, 1'b0, 32'hBFC00004, 4'b1111, 32'h0, rv, hi);
    check("rd_lanes", 0, rv, 32'hDE22BE44);
    idle(0);
    xfer(0, 1'b1, 32'hBFC00004, 4'b0000, 32'hFFFFFFFF, rv, hi);
    check("be0_hi_cycles", 0, 32'(hi), 32'd3);
    idle(0);
    xfer(0, 1'b0, 32'hBFC00004, 4'b0000, 32'h0, rv, hi);
    check("rd_after_be0", 0, rv, 32'hDE22BE44);
    idle(0);
    xfer(0, 1'b0, 32'h00000000, 4'b1111, 32'h0, rv, hi);
    check("rd_out_of_range", 0, rv, 32'h0);
    idle(0);
    @(negedge clk);
    check("oor_no_perr", 0, 32'(perr[0]), 32'h0);
    @(posedge clk); #1;
    xfer(0, 1'b0, 32'hBFC00002, 4'b1111, 32'h0, rv, hi);
    check("rd_misaligned", 0, rv, 32'h0);
    check("misal_hi_cycles", 0, 32'(hi), 32'd3);
    idle(0);
    @(negedge clk);
    check("misal_perr", 0, 32'(perr[0]), 32'h1);
    @(posedge clk); #1;

    // Dropping a read during WAIT aborts and flags an error.
    pulse_reset();
    rd_s[0] = 1'b1; addr_s[0] = 32'hBFC00004;
    @(posedge clk); #1;
    rd_s[0] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_perr", 0, 32'(perr[0]), 32'h1);
    check("abort_idle_wreq", 0, 32'(wreq[0]), 32'h0);
    @(posedge clk); #1;

    // Reset in the WAIT of a write leaves the word intact.
    pulse_reset();
    xfer(0, 1'b0, 32'hBFC00004, 4'b1111, 32'h0, rv, hi);
    check("pre_reset_rd", 0, rv, 32'hDE22BE44);
    xfer_start_write: begin
      wr_s[0] = 1'b1; rd_s[0] = 1'b0; addr_s[0] = 32'hBFC00004; be_s[0] = 4'hF; wd_s[0] = 32'hCAFEF00D;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_wreq", 0, 32'(wreq[0]), 32'h1);
    check("rst_rdata", 0, rdat[0], 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_hold_wreq", 0, 32'(wreq[0]), 32'h1);
    @(posedge clk); #1;
    wr_s[0] = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    xfer(0, 1'b0, 32'hBFC00004, 4'b1111, 32'h0, rv, hi);
    check("rd_after_rst", 0, rv, 32'hDE22BE44);
    idle(0);

    // Zero-wait-state unit: back-to-back reads, then read+write conflict.
    xfer(1, 1'b1, 32'hBFC00010, 4'b1111, 32'h01020304, rv, hi);
    xfer(1, 1'b1, 32'hBFC00020, 4'b1111, 32'hA5A55A5A, rv, hi);
    idle(1);
    xfer(1, 1'b0, 32'hBFC00010, 4'b1111, 32'h0, rv, hi);
    check("b2b_rd0_data", 1, rv, 32'h01020304);
    check("b2b_rd0_hi", 1, 32'(hi), 32'd1);
    xfer(1, 1'b0, 32'hBFC00020, 4'b1111, 32'h0, rv, hi);
    check("b2b_rd1_data", 1, rv, 32'hA5A55A5A);
    check("b2b_rd1_hi", 1, 32'(hi), 32'd1);
    rd_s[1] = 1'b1; wr_s[1] = 1'b1; addr_s[1] = 32'hBFC00010;
    @(negedge clk);
    check("both_wreq", 1, 32'(wreq[1]), 32'h0);
    @(posedge clk); #1;
    rd_s[1] = 1'b0; wr_s[1] = 1'b0;
    @(negedge clk);
    check("both_perr", 1, 32'(perr[1]), 32'h1);
    @(posedge clk); #1;

    repeat (2) @(posedge clk);
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_ram_responder.md
AVALON_RAM_RESPONDER -- requirements
Module: avalon_ram_responder

Interface
REQ-001 Parameters SHALL be: MEM_WORDS_LOG2, default 10, log2 of the word-memory depth; BASE_ADDR, default 32'hBFC00000, byte address of word 0; WAIT_CYCLES, default 2, range 0..255, extra stall cycles per transfer.
REQ-002 Ports SHALL be, in order:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- address  in  32  byte address from the bus controller.
- read  in  1  read request.
- write  in  1  write request.
- byteenable  in  4  lane enables; bit i selects writedata[8i+7:8i].
- writedata  in  32  write data.
- waitrequest  out  1  stall; transfer completes on an edge where the request is high and waitrequest is low.
- readdata  out  32  read data; valid while waitrequest=0 in the completing cycle.
- protocol_error  out  1  sticky error flag.
REQ-003 Reset SHALL be one clock (clk) with asynchronous, active-high reset (reset).

Function
REQ-004 The FSM SHALL have states IDLE, WAIT, ACK and an 8-bit down-counter cnt.
REQ-005 In IDLE with exactly one of read/write high: waitrequest=1; go to WAIT with cnt=WAIT_CYCLES-1 if WAIT_CYCLES>0, otherwise go directly to ACK.
REQ-006 In WAIT: waitrequest=1; if cnt=0 go to ACK, else cnt decrements.
REQ-007 On entry to ACK (the edge leaving IDLE or WAIT), readdata SHALL load mem[idx] for reads; for writes readdata holds its value.
REQ-008 In ACK: waitrequest=0; for writes, each lane with byteenable[i]=1 SHALL update at the edge ending ACK; next state IDLE.
REQ-009 Each transfer SHALL see waitrequest high for exactly WAIT_CYCLES+1 cycles, then low for exactly one cycle.
REQ-010 Back-to-back requests SHALL start a new transfer from IDLE in the cycle after ACK with no extra gap.
REQ-011 In IDLE with no request, waitrequest SHALL be 0 and readdata SHALL hold its value.
REQ-012 Index computation:
- idx = (address-BASE_ADDR)>>2, using bits [MEM_WORDS_LOG2+1:2].
- The address is in range when 0 <= address-BASE_ADDR < 4*2^MEM_WORDS_LOG2 (unsigned).
REQ-013 Out-of-range reads SHALL return 32'h0; out-of-range writes SHALL be dropped; neither sets protocol_error.
REQ-014 byteenable=4'b0000 writes SHALL complete with full timing and leave memory unchanged; reads SHALL ignore byteenable and return the full word.
REQ-015 Misaligned address (address[1:0]!=0): complete with normal timing, read returns 32'h0, write dropped, protocol_error set.
REQ-016 read and write both high in IDLE: no transfer; waitrequest=0; protocol_error set; stay IDLE.
REQ-017 Request dropped, or address/read/write changed, while in WAIT or ACK: abort to IDLE with no write, set protocol_error.
REQ-018 The transfer's address, read, write, byteenable and writedata SHALL be latched on leaving IDLE for the REQ-017 comparison.
REQ-019 protocol_error SHALL remain 1 until reset.

Reset
REQ-020 While reset=1: state=IDLE, cnt=0, readdata=32'h0, protocol_error=0, waitrequest=1 regardless of request.
REQ-021 Reset asserted mid-transfer SHALL abort it immediately with no memory update; memory contents are not cleared.
REQ-022 After reset deassertion, the first request SHALL be handled as from IDLE.

Verification
REQ-023 WAIT_CYCLES=2:
- Write 32'hDEADBEEF to BFC00004 with be=1111 -> waitrequest high 3 cycles, low 1.
- Read BFC00004 -> readdata=32'hDEADBEEF in the ACK cycle.
REQ-024 Byte lanes:
- Write 32'h11223344 with be=0101 over existing 32'hDEADBEEF -> readback 32'hDE22BE44.
- be=0000 -> word unchanged.
REQ-025 WAIT_CYCLES=0: back-to-back reads of two addresses -> each has 1 cycle waitrequest high then 1 cycle low, with the correct data each time.
REQ-026 Out-of-range and misaligned:
- Read 32'h00000000 -> readdata 0, protocol_error=0.
- Read BFC00002 -> readdata 0, protocol_error=1.
REQ-027 Aborts:
- Drop read during WAIT -> FSM returns to IDLE, protocol_error=1.
- Assert reset during a write's WAIT -> target word unchanged, waitrequest=1 during reset, readdata=0.
